q_meter: RTL and testbench
==========================

// Module: q_meter
// PURPOSE
//  Plant-side responder to the bisection controller. Accepts a current reference (i_ref) request and drives it to the DAC.
//  Waits a settle time, then averages 2**AVG_LOG2 ADC Q-samples and returns measured_q with a one-cycle q_valid strobe.
//  Sits between bisection (initiator) and the analog front end; replaces the table-lookup plant model used in simulation.
// PARAMETERS
//  WIDTH          10    bit width of i_ref, dac_code, adc_sample, measured_q
//  AVG_LOG2       2     log2 of samples averaged per measurement (0..4)
//  SETTLE_CYCLES  16    clk cycles between DAC update and first accepted ADC sample (>=1)
//  TIMEOUT_CYCLES 1024  max cycles in ACCUM before abort (>=2**AVG_LOG2)
// PORTS
//  clk         in   1         system clock, rising edge
//  rst         in   1         asynchronous, active-high reset
//  i_ref_valid in   1         request: new i_ref present
//  i_ref_ready out  1         block can accept a request (high only in IDLE)
//  i_ref       in   WIDTH     requested current reference
//  dac_code    out  WIDTH     code applied to current DAC
//  adc_valid   in   1         adc_sample qualifier, one sample per high cycle
//  adc_sample  in   WIDTH     raw Q measurement from ADC
//  measured_q  out  WIDTH     averaged Q, held until next result
//  q_valid     out  1         one-cycle pulse: measured_q updated
//  timeout     out  1         sticky-per-result flag: last result was aborted
//  busy        out  1         high in every state except IDLE
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, dac_code=0, measured_q=0, q_valid=0, timeout=0, busy=0, acc=0, counters=0.
//  Handshake: transfer when i_ref_valid && i_ref_ready on a rising edge; i_ref captured that edge. Requests while busy are
//   not accepted (ready=0) and are not queued; the initiator holds valid until ready.
//  FSM:
//   IDLE   : ready=1. On transfer -> APPLY.
//   APPLY  : dac_code<=captured i_ref (1 cycle); load settle counter=SETTLE_CYCLES-1 -> SETTLE.
//   SETTLE : count down; adc_valid ignored. At 0 -> ACCUM, clear acc, sample count, timeout counter.
//   ACCUM  : each adc_valid adds zero-extended adc_sample to acc (WIDTH+AVG_LOG2 bits, never overflows).
//            After 2**AVG_LOG2-th sample -> DONE. If TIMEOUT_CYCLES elapse first -> DONE with abort flag.
//   DONE   : 1 cycle. Normal: measured_q<=sat((acc + (AVG_LOG2? 2**(AVG_LOG2-1):0)) >> AVG_LOG2), round-half-up,
//            saturate at 2**WIDTH-1; timeout<=0. Abort: measured_q<=0, timeout<=1. q_valid=1 this cycle -> IDLE.
//  Latency (zero wait on adc_valid continuous): transfer edge -> q_valid = 1+SETTLE_CYCLES+2**AVG_LOG2+1 cycles.
//  dac_code holds between requests (current stays applied); changes only in APPLY.
//  Same i_ref as previous: full measurement still performed (no caching).
//  adc_valid in the cycle of the final sample count is consumed once; extra samples in DONE/IDLE are dropped.
//  Reset mid-operation: immediate return to IDLE, dac_code forced to 0 (safe current), pending result discarded.
//  q_valid and i_ref_ready never high in the same cycle (DONE precedes IDLE).
// STRUCTURE
//  q_meter_pkg: typedef enum logic [2:0] {IDLE, APPLY, SETTLE, ACCUM, DONE} q_meter_state_t; localparam for
//   counter width function clog2-based helpers shared with bisection.
//  Sub-module: q_meter_down_counter (load/enable/zero flag), instanced twice: settle counter and timeout counter.
//  Accumulator, sample counter, rounding/saturation and output regs live in q_meter.
// TESTING
//  1 Reset mid-ACCUM (rst pulse at cycle 20, WIDTH=10) -> dac_code=0, busy=0, ready=1, no q_valid.
//  2 i_ref=512, SETTLE=16, AVG_LOG2=2, adc_sample=248 every cycle -> dac_code=512, q_valid at +22 cycles, measured_q=248.
//  3 Samples 1,2,2,2 (AVG_LOG2=2) -> acc=7, (7+2)>>2 -> measured_q=2; samples 1,1,1,2 -> measured_q=1.
//  4 Samples all 1023, AVG_LOG2=2 -> measured_q=1023 (saturation path, no wrap); timeout=0.
//  5 adc_valid held 0 after SETTLE, TIMEOUT=1024 -> q_valid 1024 cycles after ACCUM entry, measured_q=0, timeout=1.
//  6 i_ref_valid held high during busy with changing i_ref -> only first value applied; second accepted in next IDLE.

Source files
------------

// File: rtl/q_meter_pkg.sv
// Shared types and sizing helpers for the Q-meter plant responder.
// The bisection controller uses the same counter-width helper.
package q_meter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    ACCUM  = 3'd3,
    DONE   = 3'd4
  } q_meter_state_t;

  localparam int Q_METER_WIDTH_DEF    = 10;
  localparam int Q_METER_AVG_LOG2_DEF = 2;

  // Bits needed to hold a down-count starting at n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/q_meter_down_counter.sv
// Loadable down counter that stops at zero and flags it.
// Used for the settle delay and the accumulation timeout.
module q_meter_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/q_meter.sv
// Plant-side responder: applies a requested current to the DAC, waits for settling,
// averages 2**AVG_LOG2 ADC Q samples and returns a rounded, saturated result.
//
// Handshake: a request transfers on a rising edge where i_ref_valid && i_ref_ready;
// i_ref is captured on that edge, ready is high only in IDLE and nothing is queued.
module q_meter
  import q_meter_pkg::*;
#(
  parameter int WIDTH          = Q_METER_WIDTH_DEF,
  parameter int AVG_LOG2       = Q_METER_AVG_LOG2_DEF,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ref_valid,
  output logic             i_ref_ready,
  input  logic [WIDTH-1:0] i_ref,
  output logic [WIDTH-1:0] dac_code,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_sample,
  output logic [WIDTH-1:0] measured_q,
  output logic             q_valid,
  output logic             timeout,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int ACC_W  = WIDTH + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam int SET_W  = cnt_w(SETTLE_CYCLES);
  localparam int TO_W   = cnt_w(TIMEOUT_CYCLES);
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [ACC_W:0]    HALF        = (ACC_W + 1)'((1 << AVG_LOG2) >> 1);
  localparam logic [ACC_W:0]    MAX_Q       = (ACC_W + 1)'((1 << WIDTH) - 1);

  q_meter_state_t    state_q, state_d;
  logic [WIDTH-1:0]  ref_q, dac_q, meas_q;
  logic [ACC_W-1:0]  acc_q, acc_sum;
  logic [SCNT_W-1:0] scnt_q;
  logic              timeout_q;
  logic              xfer, sample, last_sample;
  logic              settle_load, settle_en, settle_zero;
  logic              to_load, to_en, to_zero;
  logic [SET_W-1:0]  settle_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [ACC_W:0]    rnd;
  logic [WIDTH-1:0]  result;

  assign xfer        = i_ref_valid && i_ref_ready;
  assign sample      = (state_q == ACCUM) && adc_valid;
  assign last_sample = sample && (scnt_q == LAST_SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE:  if (settle_zero) state_d = ACCUM;
      ACCUM:   if (last_sample || to_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_ref_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    q_valid     = (state_q == DONE);
    settle_load = (state_q == APPLY);
    settle_en   = (state_q == SETTLE);
    to_load     = (state_q == SETTLE) && settle_zero;
    to_en       = (state_q == ACCUM);
  end

  q_meter_down_counter #(.W(SET_W)) u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (settle_load),
    .load_val_i (SET_W'(SETTLE_CYCLES - 1)),
    .en_i       (settle_en),
    .count_o    (settle_cnt),
    .zero_o     (settle_zero)
  );

  q_meter_down_counter #(.W(TO_W)) u_timeout_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (to_load),
    .load_val_i (TO_W'(TIMEOUT_CYCLES - 1)),
    .en_i       (to_en),
    .count_o    (to_cnt),
    .zero_o     (to_zero)
  );

  // Result includes the sample arriving this cycle so it is ready in DONE alongside q_valid.
  assign acc_sum = acc_q + ACC_W'(adc_sample);
  assign rnd     = ({1'b0, acc_sum} + HALF) >> AVG_LOG2;
  assign result  = (rnd > MAX_Q) ? '1 : rnd[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q     <= '0;
      dac_q     <= '0;
      acc_q     <= '0;
      scnt_q    <= '0;
      meas_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (xfer) ref_q <= i_ref;
      if (state_q == APPLY) dac_q <= ref_q;
      if (to_load) begin
        acc_q  <= '0;
        scnt_q <= '0;
      end else if (sample) begin
        acc_q  <= acc_sum;
        scnt_q <= scnt_q + SCNT_W'(1);
      end
      if ((state_q == ACCUM) && (state_d == DONE)) begin
        meas_q    <= last_sample ? result : '0;
        timeout_q <= !last_sample;
      end
    end
  end

  assign dac_code   = dac_q;
  assign measured_q = meas_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_q_meter.sv
// Randomized bench for q_meter: a cycle-indexed reference model decides which ADC samples
// fall inside the accumulation window and predicts result, abort flag and q_valid timing.
module tb_q_meter;

  localparam int W   = 10;
  localparam int AL  = 2;
  localparam int N   = 1 << AL;
  localparam int ST  = 16;
  localparam int TO  = 1024;
  localparam int MAXQ = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_ref_valid;
  logic         i_ref_ready;
  logic [W-1:0] i_ref;
  logic [W-1:0] dac_code;
  logic         adc_valid;
  logic [W-1:0] adc_sample;
  logic [W-1:0] measured_q;
  logic         q_valid;
  logic         timeout;
  logic         busy;
  logic [2:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus knobs: percent chance of adc_valid per cycle, and how in-window samples are chosen.
  int           vprob;
  int           smode;          // 0 random, 1 constant, 2 pattern
  logic [W-1:0] const_val;
  logic [W-1:0] pat [N];

  q_meter #(
    .WIDTH(W), .AVG_LOG2(AL), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ref_valid (i_ref_valid),
    .i_ref_ready (i_ref_ready),
    .i_ref       (i_ref),
    .dac_code    (dac_code),
    .adc_valid   (adc_valid),
    .adc_sample  (adc_sample),
    .measured_q  (measured_q),
    .q_valid     (q_valid),
    .timeout     (timeout),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request/measurement. Edge c counts rising edges after the transfer edge; the
  // accumulation window is edges ST+2 .. ST+1+TO and the first N valid samples there count.
  task automatic run_meas(input logic [W-1:0] ref_v, input bit hold, input string tag);
    int c, n, sum, exp_c, got_c, exp_q, wait_c;
    bit v, bad_ready, in_win;
    logic [W-1:0] s;
    i_ref       = ref_v;
    i_ref_valid = 1'b1;
    wait_c = 0;
    while (!i_ref_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check_eq({tag, "_ready_before"}, i_ref_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) i_ref_valid = 1'b0;
    n = 0; sum = 0; exp_c = ST + 1 + TO; got_c = -1; bad_ready = 0;
    for (c = 1; c <= ST + TO + 8; c++) begin
      in_win = (c >= ST + 2) && (c <= ST + 1 + TO);
      v = ($urandom_range(99) < vprob);
      s = W'($urandom);
      if (in_win) begin
        if (smode == 1) s = const_val;
        else if (smode == 2) s = pat[(n < N) ? n : 0];
      end
      adc_valid  = v;
      adc_sample = s;
      if (hold) i_ref = W'($urandom);
      @(posedge clk);
      if (v && in_win && n < N) begin
        sum += int'(s);
        n++;
        if (n == N) exp_c = c;
      end
      @(negedge clk);
      if (q_valid) begin
        got_c = c;
        break;
      end
      if (i_ref_ready) bad_ready = 1;
    end
    exp_q = 0;
    if (n == N) begin
      exp_q = (sum + N / 2) / N;
      if (exp_q > MAXQ) exp_q = MAXQ;
    end
    check_eq({tag, "_latency"}, got_c, exp_c);
    check_eq({tag, "_measured_q"}, measured_q, exp_q);
    check_eq({tag, "_timeout"}, timeout, (n == N) ? 0 : 1);
    check_eq({tag, "_dac_code"}, dac_code, ref_v);
    check_eq({tag, "_ready_with_qvalid"}, i_ref_ready, 0);
    check_eq({tag, "_ready_while_busy"}, bad_ready, 0);
    @(negedge clk);
    check_eq({tag, "_qvalid_one_cycle"}, q_valid, 0);
    check_eq({tag, "_ready_after"}, i_ref_ready, 1);
    check_eq({tag, "_result_held"}, measured_q, exp_q);
  endtask

  initial begin
    int qv_seen;
    rst = 1'b1; i_ref_valid = 1'b0; i_ref = '0; adc_valid = 1'b0; adc_sample = '0;
    vprob = 100; smode = 0; const_val = '0;
    for (int i = 0; i < N; i++) pat[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_dac_code", dac_code, 0);
    check_eq("rst_measured_q", measured_q, 0);
    check_eq("rst_q_valid", q_valid, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", i_ref_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Constant 248 with continuous valid: result appears at edge 1+ST+N, seen by the initiator on edge 22.
    smode = 1; const_val = 10'd248; vprob = 100;
    run_meas(10'd512, 0, "const248");

    // Reset in the middle of accumulation.
    vprob = 0;
    i_ref = 10'd300; i_ref_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ref_valid = 1'b0;
    repeat (19) @(negedge clk);
    check_eq("midrst_in_accum", dbg_state, 3);
    rst = 1'b1;
    #1;
    check_eq("midrst_dac_code", dac_code, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ready", i_ref_ready, 1);
    check_eq("midrst_q_valid", q_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    qv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      adc_valid = 1'b1; adc_sample = W'($urandom);
      @(negedge clk);
      if (q_valid) qv_seen++;
    end
    check_eq("midrst_no_qvalid", qv_seen, 0);
    check_eq("midrst_dac_still0", dac_code, 0);

    // Rounding: 1,2,2,2 -> 2 and 1,1,1,2 -> 1.
    smode = 2; vprob = 100;
    pat[0] = 10'd1; pat[1] = 10'd2; pat[2] = 10'd2; pat[3] = 10'd2;
    run_meas(10'd100, 0, "round_up");
    pat[0] = 10'd1; pat[1] = 10'd1; pat[2] = 10'd1; pat[3] = 10'd2;
    run_meas(10'd100, 0, "round_down");

    // Full-scale samples: result must stay at full scale.
    smode = 1; const_val = 10'd1023;
    run_meas(10'd1023, 0, "fullscale");

    // No ADC data: abort after the timeout window.
    vprob = 0;
    run_meas(10'd77, 0, "abort");

    // A good result after an abort clears the flag.
    vprob = 100; smode = 0;
    run_meas(10'd77, 0, "after_abort");

    // Request held during busy with a changing i_ref: only the first value is applied.
    vprob = 80; smode = 0;
    run_meas(10'd640, 1, "hold_first");
    run_meas(10'd200, 0, "hold_second");

    // Randomized requests with gapped ADC data.
    for (int k = 0; k < 8; k++) begin
      vprob = $urandom_range(30, 100);
      smode = (k % 3 == 0) ? 1 : 0;
      const_val = W'($urandom_range(900, 1023));
      run_meas(W'($urandom), 0, $sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
